if_id_stage_reg: RTL and testbench

//  Pipeline boundary between instruction fetch and decode. Captures {instruction, pc, nextpc} from IF and holds them for ID.
//  2-entry skid buffer: IF keeps fetching for one cycle after ID stalls without losing a beat.

---
 rtl/if_id_stage_reg_pkg.sv | 15 +
 rtl/if_id_stage_reg_pipe_skid_buf.sv | 76 +++++++
 rtl/if_id_stage_reg.sv | 72 +++++++
 tb/tb_if_id_stage_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_reg_pkg.sv
// Shared definitions for the IF/ID pipeline boundary: default widths and
// buffer occupancy encoding.
package if_id_stage_reg_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_CNT_W    = 16;
  localparam int ENTRY_FIELDS = 3;  // {instn, pc, nextpc}

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/if_id_stage_reg_pipe_skid_buf.sv
// Generic 2-entry skid buffer: strict FIFO of head/tail registers with
// synchronous flush; the head register feeds the consumer directly.
module pipe_skid_buf
  import if_id_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output occ_e             count,
  output logic [WIDTH-1:0] head
);

  occ_e             count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] tail_nxt;

  // NOTE: both entries are reset so a flushed or freshly reset head shows a known bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= OCC_EMPTY;
      head  <= RESET_VAL;
      tail  <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      count <= count_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a latch.
    count_nxt = count;
    head_nxt  = head;
    tail_nxt  = tail;
    if (flush) begin
      count_nxt = OCC_EMPTY;
      head_nxt  = RESET_VAL;
    end else begin
      unique case (count)
        OCC_EMPTY: begin
          if (push) begin
            head_nxt  = din;
            count_nxt = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_nxt = din;
          end else if (push) begin
            tail_nxt  = din;
            count_nxt = OCC_FULL;
          end else if (pop) begin
            count_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // The producer is stalled while full, so only a pop can happen here.
          if (pop) begin
            head_nxt  = tail;
            count_nxt = OCC_ONE;
          end
        end
        default: count_nxt = OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register built on a 2-entry skid buffer, with branch flush,
// NOP substitution toward decode and a saturating stall-cycle counter.
module if_id_stage_reg
  import if_id_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTN = '0,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instn,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_nextpc,
  output logic              if_stall,
  input  logic              id_stall,
  input  logic              flush,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instn,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_nextpc,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int                       ENTRY_W   = ENTRY_FIELDS * DATA_W;
  localparam logic [ENTRY_W-1:0]       ENTRY_NOP = {NOP_INSTN, {(2 * DATA_W){1'b0}}};

  occ_e               count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [DATA_W-1:0]  head_instn;
  logic [DATA_W-1:0]  head_pc;
  logic [DATA_W-1:0]  head_nextpc;

  // Stall and valid come from registered occupancy only, never from if_valid.
  assign if_stall = (count == OCC_FULL);
  assign id_valid = (count != OCC_EMPTY);
  assign push     = if_valid & ~if_stall & ~flush;
  assign pop      = id_valid & ~id_stall;

  pipe_skid_buf #(
    .WIDTH     (ENTRY_W),
    .RESET_VAL (ENTRY_NOP)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({if_instn, if_pc, if_nextpc}),
    .count (count),
    .head  (head)
  );

  assign {head_instn, head_pc, head_nextpc} = head;

  // A popped-out head keeps stale data, so mask it whenever nothing is held.
  assign id_instn  = id_valid ? head_instn  : NOP_INSTN;
  assign id_pc     = id_valid ? head_pc     : '0;
  assign id_nextpc = id_valid ? head_nextpc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (if_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg: ordering, stall/skid, flush, async reset
// and counter saturation (a second instance with a 4-bit counter).
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instn;
  logic [31:0] if_pc;
  logic [31:0] if_nextpc;
  logic        id_stall;
  logic        flush;

  logic        if_stall;
  logic        id_valid;
  logic [31:0] id_instn;
  logic [31:0] id_pc;
  logic [31:0] id_nextpc;
  logic [15:0] stall_cycles;

  logic        s_if_stall;
  logic        s_id_valid;
  logic [31:0] s_id_instn;
  logic [31:0] s_id_pc;
  logic [31:0] s_id_nextpc;
  logic [3:0]  s_stall_cycles;

  int errors = 0;
  int checks = 0;

  if_id_stage_reg #(.DATA_W(32), .NOP_INSTN(NOP), .CNT_W(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_instn     (if_instn),
    .if_pc        (if_pc),
    .if_nextpc    (if_nextpc),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_instn     (id_instn),
    .id_pc        (id_pc),
    .id_nextpc    (id_nextpc),
    .stall_cycles (stall_cycles)
  );

  if_id_stage_reg #(.DATA_W(32), .NOP_INSTN(NOP), .CNT_W(4)) u_sat (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_instn     (if_instn),
    .if_pc        (if_pc),
    .if_nextpc    (if_nextpc),
    .if_stall     (s_if_stall),
    .id_stall     (id_stall),
    .flush        (flush),
    .id_valid     (s_id_valid),
    .id_instn     (s_id_instn),
    .id_pc        (s_id_pc),
    .id_nextpc    (s_id_nextpc),
    .stall_cycles (s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid  = v;
    if_pc     = pc;
    if_nextpc = pc + 32'd4;
    if_instn  = v ? (32'hA500_0000 | pc) : 32'hxxxx_xxxx;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, id_valid, 1'b0);
    check({tag, "_instn"}, id_instn, NOP);
    check({tag, "_pc"}, id_pc, 32'd0);
    check({tag, "_nextpc"}, id_nextpc, 32'd0);
  endtask

  task automatic check_entry(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, id_valid, 1'b1);
    check({tag, "_pc"}, id_pc, pc);
    check({tag, "_instn"}, id_instn, 32'hA500_0000 | pc);
    check({tag, "_nextpc"}, id_nextpc, pc + 32'd4);
  endtask

  initial begin
    reset    = 1'b1;
    id_stall = 1'b0;
    flush    = 1'b0;
    drive(1'b0, 32'd0);
    #2;
    check_empty("reset");
    check("reset_if_stall", if_stall, 1'b0);
    check("reset_cnt", stall_cycles, 16'd0);
    tick();
    reset = 1'b0;

    // 1: back-to-back pushes flow straight through with one cycle latency
    drive(1'b1, 32'd0); tick(); check_entry("t1_a", 32'd0);
    drive(1'b1, 32'd4); tick(); check_entry("t1_b", 32'd4);
    check("t1_if_stall", if_stall, 1'b0);
    drive(1'b1, 32'd8); tick(); check_entry("t1_c", 32'd8);
    drive(1'b0, 32'd0); tick(); check_empty("t1_drain");

    // 2: decode stalls, buffer fills, then drains in order
    drive(1'b1, 32'd0); tick(); check_entry("t2_a", 32'd0);
    id_stall = 1'b1;
    drive(1'b1, 32'd4); tick();
    check("t2_full_stall", if_stall, 1'b1);
    check_entry("t2_hold0", 32'd0);
    drive(1'b1, 32'd8); tick(); check("t2_cnt1", stall_cycles, 16'd1);
    tick(); check("t2_cnt2", stall_cycles, 16'd2);
    id_stall = 1'b0;
    tick();
    check_entry("t2_b", 32'd4);
    check("t2_unstall", if_stall, 1'b0);
    tick(); check_entry("t2_c", 32'd8);
    drive(1'b0, 32'd0); tick(); check_empty("t2_drain");
    check("t2_cnt3", stall_cycles, 16'd3);

    // 3: flush while full drops held entries and the same-cycle fetch
    id_stall = 1'b1;
    drive(1'b1, 32'h100); tick();
    drive(1'b1, 32'h104); tick();
    check("t3_full", if_stall, 1'b1);
    flush = 1'b1;
    drive(1'b1, 32'd12); tick();
    flush = 1'b0;
    check_empty("t3_flush");
    check("t3_if_stall", if_stall, 1'b0);
    check("t3_cnt", stall_cycles, 16'd4);
    id_stall = 1'b0;
    drive(1'b1, 32'd40); tick(); check_entry("t3_after", 32'd40);
    drive(1'b0, 32'd0); tick(); check_empty("t3_alone");

    // 4: steady push and pop keeps exactly one entry in flight
    drive(1'b1, 32'h200); tick(); check_entry("t4_first", 32'h200);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i)); tick();
      check("t4_pc", id_pc, 32'h200 + 32'(4 * i));
      check("t4_if_stall", if_stall, 1'b0);
    end
    drive(1'b0, 32'd0); tick(); check_empty("t4_drain");

    // 5: asynchronous reset between edges while full
    id_stall = 1'b1;
    drive(1'b1, 32'h300); tick();
    drive(1'b1, 32'h304); tick();
    check("t5_full", if_stall, 1'b1);
    drive(1'b0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_empty("t5_async");
    check("t5_if_stall", if_stall, 1'b0);
    check("t5_cnt", stall_cycles, 16'd0);
    check("t5_sat_cnt", s_stall_cycles, 4'd0);
    tick();
    reset = 1'b0;

    // 6: long stall saturates the narrow counter without wrapping
    drive(1'b1, 32'h400); tick(); check_entry("t6_first", 32'h400);
    drive(1'b1, 32'h404); tick();
    drive(1'b0, 32'd0);
    repeat (20) tick();
    check("t6_cnt16", stall_cycles, 16'd20);
    check("t6_sat", s_stall_cycles, 4'd15);
    check_entry("t6_hold", 32'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
